// File: rtl/ahb_master_bridge_pkg.sv
// Shared AHB-Lite codes, bridge state encoding and default address map.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'b000,
    HSIZE_HALF = 3'b001,
    HSIZE_WORD = 3'b010
  } hsize_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP_ERR
  } state_e;

  localparam logic [31:0] DEF_ROM_BASE = 32'h0000_0000;
  localparam logic [31:0] DEF_ROM_SIZE = 32'h0001_0000;
  localparam logic [31:0] DEF_RAM_BASE = 32'h1000_0000;
  localparam logic [31:0] DEF_RAM_SIZE = 32'h0001_0000;

endpackage

// File: rtl/ahb_master_bridge_addr_decode.sv
// Combinational address-map decode and request legality check.
module ahb_addr_decode
  import ahb_pkg::*;
#(
  parameter logic [31:0] ROM_BASE = DEF_ROM_BASE,
  parameter logic [31:0] ROM_SIZE = DEF_ROM_SIZE,
  parameter logic [31:0] RAM_BASE = DEF_RAM_BASE,
  parameter logic [31:0] RAM_SIZE = DEF_RAM_SIZE
) (
  input  logic [31:0] addr,
  input  logic [2:0]  size,
  input  logic        write,
  input  logic        fetch,
  output logic        sel_rom,
  output logic        sel_ram,
  output logic        err
);

  logic [31:0] rom_off;
  logic [31:0] ram_off;
  logic        in_rom;
  logic        in_ram;
  logic        misaligned;

  // Region hit via unsigned offset (addresses below base wrap to large offsets),
  // alignment check, then the access-rule violations.
  always_comb begin
    rom_off = addr - ROM_BASE;
    ram_off = addr - RAM_BASE;
    in_rom  = (rom_off < ROM_SIZE);
    in_ram  = (ram_off < RAM_SIZE);
    case (size)
      HSIZE_BYTE: misaligned = 1'b0;
      HSIZE_HALF: misaligned = addr[0];
      HSIZE_WORD: misaligned = |addr[1:0];
      default:    misaligned = 1'b1;
    endcase
    err     = misaligned | ~(in_rom | in_ram) | (write & in_rom) | (fetch & ~in_rom);
    sel_rom = in_rom & ~err;
    sel_ram = in_ram & ~err;
  end

endmodule

// File: rtl/ahb_master_bridge.sv
// AHB-Lite single-transfer initiator between core requests and ROM/RAM slaves.
module ahb_master_bridge
  import ahb_pkg::*;
#(
  parameter logic [31:0] ROM_BASE = DEF_ROM_BASE,
  parameter logic [31:0] ROM_SIZE = DEF_ROM_SIZE,
  parameter logic [31:0] RAM_BASE = DEF_RAM_BASE,
  parameter logic [31:0] RAM_SIZE = DEF_RAM_SIZE,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_write,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_size,
  input  logic        req_signed,
  input  logic        req_fetch,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        HSEL1,
  output logic        HSEL2,
  output logic [31:0] haddr,
  output logic [31:0] hwdata,
  output logic        hwrite,
  output logic [2:0]  hsize,
  output logic [3:0]  hprot,
  output logic [1:0]  htrans,
  output logic        is_signed,
  input  logic [31:0] instruction,
  input  logic [31:0] load_out,
  input  logic        hready_inst,
  input  logic        hready_data,
  input  logic        hresp_inst,
  input  logic        hresp_data
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  htrans_e           htrans_q, htrans_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              hsel1_q, hsel1_d;
  logic              hsel2_q, hsel2_d;
  logic [31:0]       haddr_q, haddr_d;
  logic [31:0]       hwdata_q, hwdata_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              hwrite_q, hwrite_d;
  logic [2:0]        hsize_q, hsize_d;
  logic [3:0]        hprot_q, hprot_d;
  logic              is_signed_q, is_signed_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNT_W:0]    wait_inc;
  logic              sel_ready;
  logic              sel_resp;
  logic              dec_rom;
  logic              dec_ram;
  logic              dec_err;

  ahb_addr_decode #(
    .ROM_BASE (ROM_BASE),
    .ROM_SIZE (ROM_SIZE),
    .RAM_BASE (RAM_BASE),
    .RAM_SIZE (RAM_SIZE)
  ) u_decode (
    .addr    (req_addr),
    .size    (req_size),
    .write   (req_write),
    .fetch   (req_fetch),
    .sel_rom (dec_rom),
    .sel_ram (dec_ram),
    .err     (dec_err)
  );

  // Next-state and registered-output computation; every bus output is a flop.
  always_comb begin
    state_d     = state_q;
    htrans_d    = htrans_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    hsel1_d     = hsel1_q;
    hsel2_d     = hsel2_q;
    haddr_d     = haddr_q;
    hwdata_d    = hwdata_q;
    wdata_d     = wdata_q;
    hwrite_d    = hwrite_q;
    hsize_d     = hsize_q;
    hprot_d     = hprot_q;
    is_signed_d = is_signed_q;
    wait_cnt_d  = wait_cnt_q;
    wait_inc    = {1'b0, wait_cnt_q} + 1'b1;
    sel_ready   = hsel1_q ? hready_inst : hready_data;
    sel_resp    = hsel1_q ? hresp_inst  : hresp_data;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          wdata_d = req_wdata;
          if (dec_err) begin
            state_d     = ST_RESP_ERR;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d     = ST_ADDR;
            htrans_d    = HTRANS_NONSEQ;
            hsel1_d     = dec_rom;
            hsel2_d     = dec_ram;
            haddr_d     = req_addr;
            hwrite_d    = req_write;
            hsize_d     = req_size;
            hprot_d     = {3'b001, ~req_fetch};
            is_signed_d = req_signed;
          end
        end
      end
      ST_ADDR: begin
        state_d    = ST_DATA;
        htrans_d   = HTRANS_IDLE;
        hwdata_d   = wdata_q;
        wait_cnt_d = '0;
      end
      ST_DATA: begin
        if (sel_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = sel_resp;
          if (!sel_resp && !hwrite_q) begin
            rsp_rdata_d = hsel1_q ? instruction : load_out;
          end
          hsel1_d = 1'b0;
          hsel2_d = 1'b0;
        end else begin
          wait_cnt_d = wait_inc[CNT_W-1:0];
          if (wait_inc == (CNT_W + 1)'(TIMEOUT)) begin
            state_d     = ST_IDLE;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            hsel1_d     = 1'b0;
            hsel2_d     = 1'b0;
          end
        end
      end
      ST_RESP_ERR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Registered ready tracks the state being entered, so it is high exactly in IDLE.
    req_ready_d = (state_d == ST_IDLE);
  end

  // State and output registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      htrans_q    <= HTRANS_IDLE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      hsel1_q     <= 1'b0;
      hsel2_q     <= 1'b0;
      haddr_q     <= '0;
      hwdata_q    <= '0;
      wdata_q     <= '0;
      hwrite_q    <= 1'b0;
      hsize_q     <= '0;
      hprot_q     <= '0;
      is_signed_q <= 1'b0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      htrans_q    <= htrans_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      hsel1_q     <= hsel1_d;
      hsel2_q     <= hsel2_d;
      haddr_q     <= haddr_d;
      hwdata_q    <= hwdata_d;
      wdata_q     <= wdata_d;
      hwrite_q    <= hwrite_d;
      hsize_q     <= hsize_d;
      hprot_q     <= hprot_d;
      is_signed_q <= is_signed_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign HSEL1     = hsel1_q;
  assign HSEL2     = hsel2_q;
  assign haddr     = haddr_q;
  assign hwdata    = hwdata_q;
  assign hwrite    = hwrite_q;
  assign hsize     = hsize_q;
  assign hprot     = hprot_q;
  assign htrans    = htrans_q;
  assign is_signed = is_signed_q;

endmodule

// File: tb/tb_ahb_master_bridge.sv
// Directed scoreboard bench for ahb_master_bridge.
module tb_ahb_master_bridge;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_write;
  logic [31:0] req_wdata;
  logic [2:0]  req_size;
  logic        req_signed;
  logic        req_fetch;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        HSEL1;
  logic        HSEL2;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  logic        is_signed;
  logic [31:0] instruction;
  logic [31:0] load_out;
  logic        hready_inst;
  logic        hready_data;
  logic        hresp_inst;
  logic        hresp_data;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned lat;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc     = 0;
  int unsigned acc     = 0;

  ahb_master_bridge #(
    .ROM_BASE (32'h0000_0000),
    .ROM_SIZE (32'h0001_0000),
    .RAM_BASE (32'h1000_0000),
    .RAM_SIZE (32'h0001_0000),
    .TIMEOUT  (255)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_write   (req_write),
    .req_wdata   (req_wdata),
    .req_size    (req_size),
    .req_signed  (req_signed),
    .req_fetch   (req_fetch),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .HSEL1       (HSEL1),
    .HSEL2       (HSEL2),
    .haddr       (haddr),
    .hwdata      (hwdata),
    .hwrite      (hwrite),
    .hsize       (hsize),
    .hprot       (hprot),
    .htrans      (htrans),
    .is_signed   (is_signed),
    .instruction (instruction),
    .load_out    (load_out),
    .hready_inst (hready_inst),
    .hready_data (hready_data),
    .hresp_inst  (hresp_inst),
    .hresp_data  (hresp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_reset_outputs(input string p);
    chk({p, "_req_ready"}, req_ready, 32'd0);
    chk({p, "_rsp_valid"}, rsp_valid, 32'd0);
    chk({p, "_rsp_err"},   rsp_err,   32'd0);
    chk({p, "_rsp_rdata"}, rsp_rdata, 32'd0);
    chk({p, "_hsel1"},     HSEL1,     32'd0);
    chk({p, "_hsel2"},     HSEL2,     32'd0);
    chk({p, "_htrans"},    htrans,    32'd0);
    chk({p, "_haddr"},     haddr,     32'd0);
    chk({p, "_hwdata"},    hwdata,    32'd0);
    chk({p, "_hwrite"},    hwrite,    32'd0);
    chk({p, "_hsize"},     hsize,     32'd0);
    chk({p, "_hprot"},     hprot,     32'd0);
    chk({p, "_is_signed"}, is_signed, 32'd0);
  endtask

  task automatic push(input logic [31:0] rdata, input logic err, input int unsigned lat);
    exp_t e;
    e.rdata = rdata;
    e.err   = err;
    e.lat   = lat;
    sb.push_back(e);
  endtask

  // Waits (bounded) for ready, presents one request for a single edge.
  task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] wd,
                       input logic [2:0] sz, input logic sg, input logic f);
    int unsigned k = 0;
    while (req_ready !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    chk("issue_ready", req_ready, 32'd1);
    req_valid  = 1'b1;
    req_addr   = a;
    req_write  = w;
    req_wdata  = wd;
    req_size   = sz;
    req_signed = sg;
    req_fetch  = f;
    tick();
    acc = cyc - 1;
    req_valid = 1'b0;
  endtask

  // Waits (bounded) for a response strobe and compares it with the scoreboard head.
  task automatic wait_rsp(input string tag);
    exp_t        e;
    int unsigned k = 0;
    while (rsp_valid !== 1'b1 && k < 400) begin
      tick();
      k++;
    end
    chk({tag, "_valid"}, rsp_valid, 32'd1);
    chk({tag, "_sb_nonempty"}, (sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_lat"},   cyc - acc, e.lat);
      chk({tag, "_rdata"}, rsp_rdata, e.rdata);
      chk({tag, "_err"},   rsp_err,   e.err);
    end
  endtask

  initial begin
    int unsigned prev_acc;
    logic        seen;

    reset       = 1'b0;
    req_valid   = 1'b0;
    req_addr    = '0;
    req_write   = 1'b0;
    req_wdata   = '0;
    req_size    = '0;
    req_signed  = 1'b0;
    req_fetch   = 1'b0;
    instruction = 32'h0000_0013;
    load_out    = 32'h0000_0000;
    hready_inst = 1'b1;
    hready_data = 1'b1;
    hresp_inst  = 1'b0;
    hresp_data  = 1'b0;

    #2;
    check_reset_outputs("por");
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("ready_after_reset", req_ready, 32'd1);

    // Word fetch from ROM, zero wait states.
    push(32'h0000_0013, 1'b0, 3);
    issue(32'h0000_0010, 1'b0, 32'h0, 3'd2, 1'b0, 1'b1);
    chk("fetch_hsel1",  HSEL1,  32'd1);
    chk("fetch_hsel2",  HSEL2,  32'd0);
    chk("fetch_htrans", htrans, 32'h2);
    chk("fetch_haddr",  haddr,  32'h0000_0010);
    chk("fetch_hprot",  hprot,  32'h2);
    chk("fetch_hsize",  hsize,  32'd2);
    chk("fetch_ready_busy", req_ready, 32'd0);
    tick();
    chk("fetch_data_htrans", htrans, 32'h0);
    chk("fetch_data_hsel1",  HSEL1,  32'd1);
    wait_rsp("fetch");

    // Back-to-back fetch accepted in the response cycle.
    prev_acc    = acc;
    instruction = 32'h0051_8193;
    push(32'h0051_8193, 1'b0, 3);
    issue(32'h0000_0014, 1'b0, 32'h0, 3'd2, 1'b0, 1'b1);
    chk("b2b_interval", acc - prev_acc, 32'd3);
    wait_rsp("b2b");

    // Byte store to RAM; read data must be zero on a write.
    load_out = 32'hDEAD_BEEF;
    push(32'h0, 1'b0, 3);
    issue(32'h1000_0003, 1'b1, 32'h0000_00A5, 3'd0, 1'b0, 1'b0);
    chk("st_hsize",  hsize,  32'd0);
    chk("st_hwrite", hwrite, 32'd1);
    chk("st_hsel2",  HSEL2,  32'd1);
    chk("st_hsel1",  HSEL1,  32'd0);
    chk("st_hprot",  hprot,  32'h3);
    tick();
    chk("st_hwdata", hwdata, 32'h0000_00A5);
    wait_rsp("st");

    // Signed half load with 3 wait states; ROM handshakes driven to idle/error to show they are ignored.
    load_out    = 32'h0000_8765;
    hready_data = 1'b0;
    hready_inst = 1'b0;
    hresp_inst  = 1'b1;
    push(32'h0000_8765, 1'b0, 6);
    issue(32'h1000_0002, 1'b0, 32'h0, 3'd1, 1'b1, 1'b0);
    chk("lh_is_signed", is_signed, 32'd1);
    chk("lh_hsize",     hsize,     32'd1);
    tick();
    tick();
    tick();
    tick();
    hready_data = 1'b1;
    wait_rsp("lh_wait");
    hready_inst = 1'b1;
    hresp_inst  = 1'b0;

    // Local decode errors: response in the cycle after acceptance, no slave selected.
    push(32'h0, 1'b1, 1);
    issue(32'h1000_0001, 1'b0, 32'h0, 3'd1, 1'b0, 1'b0);
    chk("mis_hsel1", HSEL1, 32'd0);
    chk("mis_hsel2", HSEL2, 32'd0);
    chk("mis_htrans", htrans, 32'h0);
    chk("mis_ready", req_ready, 32'd0);
    wait_rsp("mis");

    push(32'h0, 1'b1, 1);
    issue(32'h2000_0000, 1'b0, 32'h0, 3'd2, 1'b0, 1'b0);
    chk("unmap_hsel1", HSEL1, 32'd0);
    chk("unmap_hsel2", HSEL2, 32'd0);
    wait_rsp("unmap");

    push(32'h0, 1'b1, 1);
    issue(32'h0000_0004, 1'b1, 32'h1234_5678, 3'd2, 1'b0, 1'b0);
    chk("romwr_hsel1", HSEL1, 32'd0);
    chk("romwr_hsel2", HSEL2, 32'd0);
    wait_rsp("romwr");

    push(32'h0, 1'b1, 1);
    issue(32'h1000_0000, 1'b0, 32'h0, 3'd2, 1'b0, 1'b1);
    chk("fetch_ram_hsel2", HSEL2, 32'd0);
    wait_rsp("fetch_ram");

    // Slave never ready: local timeout after 255 DATA wait cycles.
    hready_data = 1'b0;
    push(32'h0, 1'b1, 257);
    issue(32'h1000_0000, 1'b0, 32'h0, 3'd2, 1'b0, 1'b0);
    wait_rsp("timeout");
    chk("timeout_ready", req_ready, 32'd1);
    hready_data = 1'b1;

    // Slave error response.
    hresp_data = 1'b1;
    push(32'h0, 1'b1, 3);
    issue(32'h1000_0008, 1'b0, 32'h0, 3'd2, 1'b0, 1'b0);
    wait_rsp("hresp");
    hresp_data = 1'b0;

    // Reset while in DATA: transfer abandoned, no response afterwards.
    hready_data = 1'b0;
    issue(32'h1000_000C, 1'b0, 32'h0, 3'd2, 1'b0, 1'b0);
    tick();
    chk("rst_mid_hsel2", HSEL2, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    hready_data = 1'b1;
    tick();
    tick();
    #2;
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen = seen | rsp_valid;
    end
    chk("rst_no_rsp", seen, 32'd0);
    chk("rst_ready", req_ready, 32'd1);

    chk("sb_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
